// File: rtl/pulse_stretch_moore_if.sv
// Trigger/level bundle for pulse_stretch_moore.
// master drives in_i; slave returns o_q, o_busy, o_st.
interface pulse_stretch_moore_if;
  logic       in_i;
  logic       o_q;
  logic       o_busy;
  logic [1:0] o_st;

  modport master (
    output in_i,
    input  o_q,
    input  o_busy,
    input  o_st
  );

  modport slave (
    input  in_i,
    output o_q,
    output o_busy,
    output o_st
  );
endinterface

// File: rtl/pulse_stretch_moore.sv
// Moore pulse-to-level regenerator: strobe -> WIDTH high, GAP low guard.
// Ports: in_clk, in_rst (async, active-low), io.slave (in_i/o_q/o_busy/o_st).
// PULSE_STRETCH_RETRIGGER_EN: in_i in HIGH reloads the high phase.
module pulse_stretch_moore #(
  parameter int WIDTH = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  pulse_stretch_moore_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] W_LD =
    CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] G_LD =
    CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             q_r;
  logic             busy_r;

  // Outputs are registered next to the state so
  // they always match the state they decode.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      q_r    <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_i) begin
            state  <= S_HIGH;
            cnt    <= W_LD;
            q_r    <= 1'b1;
            busy_r <= 1'b1;
          end
        end
        S_HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
          // Reload beats the exit to GAP.
          if (io.in_i) begin
            cnt <= W_LD;
          end else if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            state  <= S_GAP;
            cnt    <= G_LD;
            q_r    <= 1'b0;
            busy_r <= 1'b1;
          end
`else
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            state  <= S_GAP;
            cnt    <= G_LD;
            q_r    <= 1'b0;
            busy_r <= 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            state  <= S_IDLE;
            q_r    <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        default: begin
          // Illegal code 3 falls back to IDLE.
          state  <= S_IDLE;
          cnt    <= '0;
          q_r    <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign io.o_q    = q_r;
  assign io.o_busy = busy_r;
  assign io.o_st   = state;

endmodule

// File: doc/pulse_stretch_moore.md
# pulse_stretch_moore

Moore-style pulse-to-level regenerator: the inverse of the rising-edge detector. It turns a single-cycle strobe on `in_i` into a clean high level on `o_q` lasting exactly `WIDTH` clock cycles, then enforces a low guard interval of `GAP` cycles before it can fire again. It sits downstream of the edge detector in the simple_fsm set, rebuilding a fixed-width level from the detected edges for LEDs, enables and handshake strobes.

## Interface
- `WIDTH`, default 4: number of cycles `o_q` stays high per trigger; legal range 1..2^CNT_W.
- `GAP`, default 2: number of low guard cycles after each high phase; legal range 1..2^CNT_W.
- `CNT_W`, default 8: width of the internal down-counter.
- `in_clk`  input  1: single clock; all state updates on its rising edge.
- `in_rst`  input  1: asynchronous, active-low reset (0 = reset asserted).
- `in_i`  input  1: trigger, sampled on each rising edge of `in_clk`; level-sensitive.
- `o_q`  output  1: stretched pulse; registered, decoded from state only.
- `o_busy`  output  1: 1 whenever state ≠ IDLE.
- `o_st`  output  2: current state code for debug/bench display.

## Operation
- States and codes: IDLE=2'd0, HIGH=2'd1, GAP=2'd2. Code 2'd3 is illegal; the FSM returns to IDLE on the next edge.
- Moore outputs:
  - IDLE: `o_q`=0, `o_busy`=0.
  - HIGH: `o_q`=1, `o_busy`=1.
  - GAP: `o_q`=0, `o_busy`=1.
- IDLE:
  - `in_i`=1 → HIGH, counter loads WIDTH-1.
  - `in_i`=0 → stay in IDLE.
- HIGH:
  - counter ≠ 0 → decrement.
  - counter = 0 → GAP, counter loads GAP-1.
- GAP:
  - counter ≠ 0 → decrement.
  - counter = 0 → IDLE.
  - `in_i` is ignored in this state.
- Counter arithmetic is unsigned CNT_W bits. Loads are truncated to CNT_W bits. The counter never decrements below 0.
- `in_i` held high continuously gives a repeating train: WIDTH high cycles, then GAP+1 low cycles (GAP guard cycles plus one IDLE sampling cycle).
- Reset asserted (`in_rst`=0) at any time, including mid-HIGH or mid-GAP:
  - takes effect immediately, without waiting for a clock edge;
  - state=IDLE, counter=0, `o_q`=0, `o_busy`=0, `o_st`=0.
- Reset release: the first trigger is sampled on the first rising edge after `in_rst` goes high.

## Timing
- Trigger latency: `in_i`=1 sampled at edge k in IDLE → `o_q` rises just after edge k (registered, no combinational path from `in_i`).
- `o_q` stays high from edge k through edge k+WIDTH-1, and falls just after edge k+WIDTH.
- GAP occupies edges k+WIDTH .. k+WIDTH+GAP-1. IDLE is re-entered at edge k+WIDTH+GAP.
- Earliest next trigger is sampled at edge k+WIDTH+GAP+1.
- A trigger arriving in the same cycle that HIGH→GAP or GAP→IDLE is taken is ignored, except when retriggering is compiled in (see Configuration).
- `o_busy` and `o_st` change on the same edges as `o_q`.

## Configuration
- Macro: `PULSE_STRETCH_RETRIGGER_EN`.
- Defined:
  - In HIGH, `in_i`=1 reloads the counter to WIDTH-1 and stays in HIGH, so the high phase extends to WIDTH cycles after the last trigger.
  - This includes the cycle where the counter is 0: the reload wins over the transition to GAP.
  - GAP still ignores `in_i`.
- Undefined:
  - `in_i` is ignored in HIGH and GAP.
  - Every high phase is exactly WIDTH cycles.

## Test plan
All scenarios use WIDTH=4, GAP=2, 20-unit clock period. Display `o_st` every edge.
- Single strobe: `in_i` high for one cycle at edge 2 → `o_q`=1 for edges 2–5, `o_st` sequence 1,1,1,1,2,2,0, `o_busy` low from edge 8.
- Held-high `in_i` for 20 cycles → `o_q` pattern 4 high / 3 low repeating, rising at edges 2, 9, 16.
- Strobe during GAP (edge 6) → no effect; `o_q` stays 0, `o_st` returns to 0 at edge 8.
- Retrigger: strobes at edges 2 and 4.
  - With `PULSE_STRETCH_RETRIGGER_EN`: `o_q` high edges 2–7.
  - Without it: `o_q` high edges 2–5 only.
- Async reset: pulse `in_rst` low for 1 time unit mid-HIGH (between edges 3 and 4) → `o_q`, `o_busy`, `o_st` go to 0 immediately. A strobe at the first edge after release restarts a full 4-cycle pulse.
- Boundary: WIDTH=1, GAP=1, single strobe → `o_q` high for exactly one cycle. With `in_i` held high, `o_q` repeats 1 high / 2 low.
